// File: rtl/fsm_table_engine.sv
// fsm_table_engine: table-driven Moore FSM with a runtime-loadable transition/output RAM
//   clk, reset      : clock, synchronous active-high reset
//   run, in_vec     : step enable and FSM input, sampled on stepping edges
//   cfg_we/addr/wdata/rdata : table write port and registered 1-cycle readback
//   busy, cfg_err   : post-reset sweep in progress, dropped-write pulse
//   state, out_vec, trans   : current state, registered output, state-change pulse
module fsm_table_engine #(
   parameter int SW = 3,
   parameter int IW = 1,
   parameter int OW = 3,
   parameter int RESET_STATE = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic [IW-1:0]     in_vec,
   input  logic              cfg_we,
   input  logic [SW+IW-1:0]  cfg_addr,
   input  logic [SW+OW-1:0]  cfg_wdata,
   output logic [SW+OW-1:0]  cfg_rdata,
   output logic              busy,
   output logic              cfg_err,
   output logic [SW-1:0]     state,
   output logic [OW-1:0]     out_vec,
   output logic              trans
);
   localparam int AW = SW + IW;
   localparam int EW = SW + OW;
   localparam logic [SW-1:0] RS = SW'(RESET_STATE);
   localparam logic [AW-1:0] LAST = '1;

   logic [EW-1:0] mem [2**AW];
   logic [AW-1:0] ptr;
   logic [EW-1:0] e;
   logic          we_ok;
   logic [AW-1:0] waddr;
   logic [EW-1:0] wdata;

   // the sweep owns the write port while busy; config writes only land when idle
   always_comb begin
      e     = mem[{in_vec, state}];
      we_ok = !reset && (busy || (cfg_we && !run));
      waddr = busy ? ptr : cfg_addr;
      wdata = busy ? {RS, {OW{1'b0}}} : cfg_wdata;
   end

   always_ff @(posedge clk)
      if (we_ok) mem[waddr] <= wdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RS;
         out_vec   <= '0;
         trans     <= 1'b0;
         cfg_err   <= 1'b0;
         cfg_rdata <= '0;
         busy      <= 1'b1;
         ptr       <= '0;
      end else begin
         cfg_rdata <= mem[cfg_addr];
         cfg_err   <= cfg_we && (busy || run);
         trans     <= 1'b0;
         if (busy) begin
            ptr  <= ptr + 1'b1;
            busy <= ptr != LAST;
         end else if (run) begin
            state   <= e[EW-1:OW];
            out_vec <= e[OW-1:0];
            trans   <= e[EW-1:OW] != state;
         end
      end
   end
endmodule

// File: tb/tb_fsm_table_engine.sv
// tb_fsm_table_engine: scoreboard bench for fsm_table_engine
module tb_fsm_table_engine;
   logic       clk = 0, reset = 1, run = 0, cfg_we = 0;
   logic [0:0] in_vec = 0;
   logic [3:0] cfg_addr = 0;
   logic [5:0] cfg_wdata = 0, cfg_rdata;
   logic       busy, cfg_err, trans;
   logic [2:0] state, out_vec;
   logic [2:0] cur = 3'd2;
   int nerr = 0, nchk = 0;

   typedef struct {string tag; int k; logic [5:0] e;} exp_t;
   exp_t q[$];

   fsm_table_engine dut (
      .clk(clk), .reset(reset), .run(run), .in_vec(in_vec),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cfg_rdata(cfg_rdata), .busy(busy), .cfg_err(cfg_err),
      .state(state), .out_vec(out_vec), .trans(trans)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [5:0] act(input int k);
      return k == 0 ? cfg_rdata : k == 1 ? {3'b0, state} : k == 2 ? {3'b0, out_vec} : {5'b0, trans};
   endfunction

   task automatic push(input string tag, input int k, input logic [5:0] e);
      exp_t x;
      x.tag = tag; x.k = k; x.e = e;
      q.push_back(x);
   endtask

   task automatic tick();
      exp_t x;
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
         x = q.pop_front();
         check(x.tag, {10'b0, act(x.k)}, {10'b0, x.e});
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [5:0] d);
      run = 0; cfg_we = 1; cfg_addr = a; cfg_wdata = d;
      tick();
      cfg_we = 0;
      check("wr_err", {15'b0, cfg_err}, 16'd0);
   endtask

   task automatic rd(input logic [3:0] a, input logic [5:0] d);
      cfg_addr = a;
      push("rdata", 0, d);
      tick();
   endtask

   task automatic step(input logic i, input logic [2:0] nx);
      in_vec = i; run = 1;
      push("step_state", 1, {3'b0, nx});
      push("step_out", 2, {3'b0, nx});
      push("step_trans", 3, {5'b0, nx != cur});
      cur = nx;
      tick();
   endtask

   task automatic hold();
      run = 0;
      push("hold_state", 1, {3'b0, cur});
      push("hold_out", 2, {3'b0, cur});
      push("hold_trans", 3, 6'd0);
      tick();
   endtask

   task automatic sweep_count(input string tag);
      int n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      check(tag, 16'(n), 16'd16);
   endtask

   logic [3:0] wa [11] = '{4'd2, 4'd4, 4'd12, 4'd6, 4'd14, 4'd7, 4'd15, 4'd1, 4'd9, 4'd10, 4'd3};
   logic [5:0] wd [11] = '{6'o44, 6'o66, 6'o11, 6'o77, 6'o77, 6'o22, 6'o44, 6'o66, 6'o66, 6'o44, 6'o20};

   initial begin
      tick();
      tick();
      check("rst_state", {13'b0, state}, 16'd2);
      check("rst_out", {13'b0, out_vec}, 16'd0);
      check("rst_trans", {15'b0, trans}, 16'd0);
      check("rst_err", {15'b0, cfg_err}, 16'd0);
      check("rst_rdata", {10'b0, cfg_rdata}, 16'd0);
      check("rst_busy", {15'b0, busy}, 16'd1);
      reset = 0;
      sweep_count("sweep1");
      check("sweep_state", {13'b0, state}, 16'd2);
      for (int a = 0; a < 16; a++) rd(4'(a), 6'o20);
      for (int i = 0; i < 10; i++) wr(wa[i], wd[i]);
      for (int i = 0; i < 11; i++) rd(wa[i], wd[i]);
      step(0, 4); step(0, 6); step(0, 7); step(0, 2);
      step(0, 4); step(1, 1); step(1, 6); step(1, 7); step(1, 4); step(1, 1);
      step(1, 6); step(1, 7); step(0, 2);
      hold(); hold();
      run = 1; in_vec = 0; cfg_we = 1; cfg_addr = 4'd2; cfg_wdata = 6'o00;
      push("wrun_state", 1, 6'd4);
      cur = 3'd4;
      tick();
      check("err_run", {15'b0, cfg_err}, 16'd1);
      cfg_we = 0;
      step(0, 6);
      check("err_run_clr", {15'b0, cfg_err}, 16'd0);
      run = 0;
      rd(4'd2, 6'o44);
      step(0, 7); step(0, 2);
      wr(4'd2, 6'o22);
      step(0, 2); step(0, 2);
      step(1, 4); hold(); hold(); step(1, 1); step(1, 6); step(1, 7);
      reset = 1; run = 1; cfg_we = 1; cfg_addr = 4'd5; cfg_wdata = 6'o55;
      tick();
      check("rr_state", {13'b0, state}, 16'd2);
      check("rr_out", {13'b0, out_vec}, 16'd0);
      check("rr_trans", {15'b0, trans}, 16'd0);
      check("rr_busy", {15'b0, busy}, 16'd1);
      check("rr_err", {15'b0, cfg_err}, 16'd0);
      cur = 3'd2;
      reset = 0; run = 0;
      tick();
      check("err_sweep", {15'b0, cfg_err}, 16'd1);
      cfg_we = 0;
      tick();
      check("err_sweep_clr", {15'b0, cfg_err}, 16'd0);
      run = 1;
      tick();
      check("sweep_run_state", {13'b0, state}, 16'd2);
      check("sweep_run_trans", {15'b0, trans}, 16'd0);
      run = 0;
      repeat (3) tick();
      check("mid_busy", {15'b0, busy}, 16'd1);
      reset = 1;
      tick();
      reset = 0;
      sweep_count("sweep2");
      rd(4'd2, 6'o20); rd(4'd5, 6'o20); rd(4'd10, 6'o20);
      check("end_state", {13'b0, state}, 16'd2);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
